// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and stage-record type for the hazard controller and the D-stage decoder.
package hazard_ctrl_pkg;

  typedef logic [2:0] res_t;
  localparam res_t RES_NW    = 3'd0;
  localparam res_t RES_ALU   = 3'd1;
  localparam res_t RES_DM    = 3'd2;
  localparam res_t RES_PC    = 3'd3;
  localparam res_t RES_OTHER = 3'd4;

  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_NONE = 2'd0;
  localparam fwd_t FWD_E    = 2'd1;
  localparam fwd_t FWD_M    = 2'd2;
  localparam fwd_t FWD_W    = 2'd3;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    res_t       res;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tnew;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '{res: RES_NW, dst: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 2'd0};

  function automatic logic hit(input stage_rec_t s, input logic [4:0] r);
    return (r != 5'd0) && (s.res != RES_NW) && (s.dst == r);
  endfunction

  // Cycles until the result exists, counted from the instruction entering E.
  function automatic logic [1:0] tnew_entry(input res_t res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Busy window of the HI/LO multiply/divide unit: load on start, count down to zero.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A new start restarts the window rather than extending it.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = start || (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: Tuse/Tnew stall detection, forwarding selects,
// and HI/LO busy interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [2:0] res_d,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] dst_d,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_div_e,
  output logic       stall,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic [1:0] fwd_rs_e,
  output logic [1:0] fwd_rt_e,
  output logic       fwd_rt_m,
  output logic       md_busy
);

  stage_rec_t d_rec;
  stage_rec_t e_q, m_q, w_q;
  stage_rec_t e_d, m_d, w_d;
  logic       data_stall;
  logic       md_stall;

  // Only the youngest in-flight writer of a register decides whether D must wait.
  function automatic logic src_stall(input stage_rec_t e, input stage_rec_t m,
                                     input logic [4:0] r, input logic [1:0] tuse);
    if (tuse == TUSE_NONE) return 1'b0;
    if (hit(e, r)) return e.tnew > tuse;
    if (hit(m, r)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic fwd_t fwd_d_sel(input stage_rec_t e, input stage_rec_t m,
                                     input stage_rec_t w, input logic [4:0] r);
    if (hit(e, r)) return (e.tnew == 2'd0) ? FWD_E : FWD_NONE;
    if (hit(m, r)) return (m.tnew == 2'd0) ? FWD_M : FWD_NONE;
    if (hit(w, r)) return (w.tnew == 2'd0) ? FWD_W : FWD_NONE;
    return FWD_NONE;
  endfunction

  function automatic fwd_t fwd_e_sel(input stage_rec_t m, input stage_rec_t w,
                                     input logic [4:0] r);
    if (hit(m, r)) return (m.tnew == 2'd0) ? FWD_M : FWD_NONE;
    if (hit(w, r)) return (w.tnew == 2'd0) ? FWD_W : FWD_NONE;
    return FWD_NONE;
  endfunction

  always_comb begin
    d_rec      = REC_BUBBLE;
    d_rec.res  = (dst_d == 5'd0) ? RES_NW : res_d;
    d_rec.dst  = dst_d;
    d_rec.rs   = rs_d;
    d_rec.rt   = rt_d;
    d_rec.tnew = tnew_entry(d_rec.res);
  end

  always_comb begin
    data_stall = src_stall(e_q, m_q, rs_d, tuse_rs_d) || src_stall(e_q, m_q, rt_d, tuse_rt_d);
    md_stall   = md_use_d && md_busy;
    stall      = data_stall || md_stall;
    fwd_rs_d   = fwd_d_sel(e_q, m_q, w_q, rs_d);
    fwd_rt_d   = fwd_d_sel(e_q, m_q, w_q, rt_d);
    fwd_rs_e   = fwd_e_sel(m_q, w_q, e_q.rs);
    fwd_rt_e   = fwd_e_sel(m_q, w_q, e_q.rt);
    fwd_rt_m   = hit(w_q, m_q.rt);
  end

  always_comb begin
    e_d      = stall ? REC_BUBBLE : d_rec;
    m_d      = e_q;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    w_d      = m_q;
    w_d.tnew = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= REC_BUBBLE;
      m_q <= REC_BUBBLE;
      w_q <= REC_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_e),
    .is_div (md_div_e),
    .busy   (md_busy)
  );

  // W's source fields and M's rs are carried for completeness but never compared.
  logic unused_rec;
  assign unused_rec = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Takes per-instruction Tuse/Tnew classification from the D-stage decoder, tracks each in-flight writer's Tnew through E/M/W, and drives the D-stage stall/bubble and every forwarding-mux select. Also sequences the HI/LO multiply/divide unit's busy window and stalls HI/LO consumers while it runs.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E
- clk  input  1  core clock
- reset  input  1  synchronous, active-high; clears all stage records and the busy counter
- tuse_rs_d, tuse_rt_d  input  2 each  cycles until D instr needs rs/rt (0..2; 3 = unused)
- res_d  input  3  result class of D instr (RES_NW/ALU/DM/PC/OTHER)
- rs_d, rt_d, dst_d  input  5 each  D instr source regs and destination reg
- md_use_d  input  1  D instr reads/writes HI/LO or starts mult/div
- md_start_e, md_div_e  input  1 each  instr in E starts mult/div; 1 = divide
- stall  output  1  hold PC and F/D register, bubble into D/E register
- fwd_rs_d, fwd_rt_d  output  2 each  D compare/jr operand source: FWD_NONE/E/M/W
- fwd_rs_e, fwd_rt_e  output  2 each  ALU operand source: FWD_NONE/M/W
- fwd_rt_m  output  1  DM write-data source: 0 = pipeline, 1 = W
- md_busy  output  1  multiply/divide unit busy

## Operation
- Stage record {res, dst, rs, rt, tnew[1:0]} held for E, M, W. D record built from inputs; its res=RES_NW when dst_d==0.
- Tnew on entry to E: ALU→1, DM→2, PC/OTHER→0, NW→0. E→M: tnew saturating-decrement. M→W: tnew forced 0.
- Hit(stage, reg): reg!=0 && stage.res!=RES_NW && stage.dst==reg.
- Data stall: for rs (if tuse_rs_d!=3) and rt (if tuse_rt_d!=3), Hit(E or M, reg) with stage.tnew > tuse; only the youngest hitting stage counts.
- MD stall: md_use_d && md_busy.
- stall = data stall OR MD stall.
- D forwards: youngest hitting stage among E, M, W with tnew==0 → FWD_E/M/W; none → FWD_NONE. Youngest hit with tnew>0 → FWD_NONE (stall covers it).
- E forwards: compare E.rs/E.rt against M then W with tnew==0; M priority.
- fwd_rt_m = Hit(W, M.rt).
- Advance every cycle: W←M, M←E (decremented), E←(stall ? bubble record with res=RES_NW, regs 0 : D record).
- Busy counter: md_start_e loads DIV_CYCLES or MULT_CYCLES; else decrement to 0. md_busy = md_start_e || counter!=0.

## Timing
- stall, all fwd_* and md_busy combinational from current inputs and registered records; no latency beyond that.
- Records and counter update on posedge clk only.
- Reset: all records RES_NW/dst 0, counter 0 → stall=0, all fwd_*=0, md_busy=0 (given md_start_e=0) from first cycle after reset.
- Reset during active stall or busy window: cleared next edge, no residual stall.
- md_start_e while counter nonzero: reload (restart), no accumulation.
- Register 0 never stalls and never forwards.
- A data stall and an MD stall in the same cycle produce one stall; one bubble per stalled cycle.

## Structure
- Shared package: RES_NW=0, RES_ALU=1, RES_DM=2, RES_PC=3, RES_OTHER=4; FWD_NONE=0, FWD_E=1, FWD_M=2, FWD_W=3; TUSE_NONE=3; stage-record typedef. The D-stage decoder includes the same package.
- One sub-module: md_busy_cnt (load/decrement counter, parameters MULT_CYCLES/DIV_CYCLES).

## Test plan
- lw $8 then addu $9,$8,$8: stall=1 exactly one cycle; next cycle stall=0, fwd_rs_d=FWD_NONE; following cycle fwd_rs_e=fwd_rt_e=FWD_W.
- addu $8 then beq $8,$0: stall=1 one cycle, then fwd_rs_d=FWD_M, fwd_rt_d=FWD_NONE.
- jal then jr $31: no stall, fwd_rs_d=FWD_E.
- ori $8 then sw $8 with no gap: no stall; when sw in M, fwd_rt_m=1 from W... sw in E gets fwd_rt_e=FWD_M.
- writes to $0 (addu $0 then beq $0): stall=0, all fwd=FWD_NONE.
- div in E then mfhi in D: md_busy=1 and stall=1 for 11 cycles (start cycle + 10); mult gives 6; assert reset at cycle 3 → stall=0, md_busy=0 after next edge.
